// File: rtl/nios2_jtag_dbg_cmd_bridge.sv
// nios2_jtag_dbg_cmd_bridge
//
// System-clock command bridge for the Nios II JTAG debug path. The bridge
// sits between virtual-JTAG state strobes and the debug targets. The
// strobes are already synchronised into clk upstream. The bridge provides
// an (DATA_W+2)-bit shift register, per-channel capture readback and a
// valid/ready command handshake with sticky overrun detection.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   ir_in               instruction (channel select) from the JTAG node
//   vs_uir/cdr/sdr/udr  update-IR, capture-DR, shift-DR, update-DR strobes
//   tdi / tdo           serial data in / out (tdo = sr[0])
//   cap_data            per-channel readback, channel k at [k*DATA_W +: DATA_W]
//   jdo                 last accepted update word
//   act_valid/ch/mode   pending command, its channel and its action mode
//   act_ready           target accepts the pending command
//   overrun             sticky: an update was dropped while a command pended
module nios2_jtag_dbg_cmd_bridge #(
  parameter int DATA_W = 32,
  parameter int IR_W   = 2,
  parameter int NCH    = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [IR_W-1:0]        ir_in,
  input  logic                   vs_uir,
  input  logic                   vs_cdr,
  input  logic                   vs_sdr,
  input  logic                   vs_udr,
  input  logic                   tdi,
  output logic                   tdo,
  input  logic [NCH*DATA_W-1:0]  cap_data,
  output logic [DATA_W+1:0]      jdo,
  output logic                   act_valid,
  output logic [IR_W-1:0]        act_ch,
  output logic [1:0]             act_mode,
  input  logic                   act_ready,
  output logic                   overrun
);

  localparam int SR_W = DATA_W + 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t            state_q;
  logic [IR_W-1:0]   ir_lat_q, ir_lat_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [SR_W-1:0]   jdo_q;
  logic [IR_W-1:0]   act_ch_q;
  logic [1:0]        act_mode_q;
  logic              overrun_q, overrun_d;

  logic              ch_ok;
  logic [DATA_W-1:0] cap_sel;
  logic              load_cmd;
  logic              ovr_set;

  // Channels at or above NCH are unimplemented: they read back zero and
  // their updates are ignored.
  assign ch_ok = int'(ir_lat_q) < NCH;

  // NOTE: every variable written here gets a default first, so the block
  // stays purely combinational and no latch is inferred.
  always_comb begin
    cap_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ir_lat_q == IR_W'(k)) cap_sel = cap_data[k*DATA_W +: DATA_W];
    end
  end

  // A new command loads from IDLE, or from PEND when the pending one is
  // accepted in the same cycle. Otherwise an update in PEND is dropped.
  assign load_cmd = vs_udr && ch_ok && (state_q == ST_IDLE || act_ready);
  assign ovr_set  = vs_udr && ch_ok && (state_q == ST_PEND) && !act_ready;

  always_comb begin
    ir_lat_d  = vs_uir ? ir_in : ir_lat_q;
    sr_d      = sr_q;
    overrun_d = overrun_q;
    if (vs_uir) begin
      sr_d = '0;
    end else if (vs_cdr) begin
      sr_d = {overrun_q, state_q == ST_PEND, cap_sel};
      overrun_d = 1'b0;   // read-to-clear; a same-cycle set wins below
    end else if (vs_sdr) begin
      sr_d = {tdi, sr_q[SR_W-1:1]};
    end
    if (ovr_set) overrun_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values. That is also how vs_udr sees the old sr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ir_lat_q   <= '0;
      sr_q       <= '0;
      jdo_q      <= '0;
      act_ch_q   <= '0;
      act_mode_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      ir_lat_q  <= ir_lat_d;
      sr_q      <= sr_d;
      overrun_q <= overrun_d;
      if (load_cmd) begin
        jdo_q      <= sr_q;
        act_ch_q   <= ir_lat_q;
        act_mode_q <= sr_q[SR_W-1 -: 2];
      end
      case (state_q)
        ST_IDLE: if (load_cmd) state_q <= ST_PEND;
        // An update on an unimplemented channel is ignored, so a ready in
        // that cycle still retires the pending command.
        ST_PEND: if (!load_cmd && act_ready) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tdo       = sr_q[0];
  assign jdo       = jdo_q;
  assign act_valid = (state_q == ST_PEND);
  assign act_ch    = act_ch_q;
  assign act_mode  = act_mode_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/nios2_jtag_dbg_cmd_bridge.md
# nios2_jtag_dbg_cmd_bridge

Parametrised system-clock command bridge for the Nios II JTAG debug path. It sits between the virtual-JTAG state strobes (already synchronised into the `clk` domain upstream) and the debug targets (OCI memory, break, trace). It generalises the fixed 38-bit, 2-bit-IR debug register to N channels of configurable data width, with per-channel capture readback. Commands are delivered through a valid/ready handshake with overrun detection, replacing fire-and-forget action pulses.

## Interface
Parameters:
- `DATA_W`, 32: payload width; shift register width `SR_W = DATA_W+2`.
- `IR_W`, 2: instruction (channel select) width.
- `NCH`, 4: implemented channels, 1..2**IR_W.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ir_in`  in  IR_W  instruction value from the virtual JTAG node.
- `vs_uir`  in  1  update-IR strobe, one cycle.
- `vs_cdr`  in  1  capture-DR strobe, one cycle.
- `vs_sdr`  in  1  shift-DR strobe; one bit shifted per asserted cycle.
- `vs_udr`  in  1  update-DR strobe, one cycle.
- `tdi`  in  1  serial data in, valid with `vs_sdr`.
- `tdo`  out  1  serial data out, equals `sr[0]`.
- `cap_data`  in  NCH*DATA_W  readback per channel; channel k at `[k*DATA_W +: DATA_W]`.
- `jdo`  out  SR_W  last accepted update word.
- `act_valid`  out  1  command pending.
- `act_ch`  out  IR_W  channel of the pending command.
- `act_mode`  out  2  `jdo[SR_W-1:SR_W-2]`; 2'b00 = no-action, other values = target-defined action.
- `act_ready`  in  1  target accepts the command.
- `overrun`  out  1  sticky: an update was lost because the previous command was still pending.

## Operation
- Registers:
  - `ir_lat` (IR_W)
  - `sr` (SR_W)
  - `jdo`
  - `act_valid`, `act_ch`, `act_mode`
  - `overrun`
- `vs_uir`: `ir_lat <= ir_in`; `sr <= 0`.
- `vs_cdr`: `sr <= {overrun, act_valid, cap_data[ir_lat]}`. If `ir_lat >= NCH`, the data field loads zero. Capture clears `overrun` (read-to-clear), except in a cycle that also sets it.
- `vs_sdr`: `sr <= {tdi, sr[SR_W-1:1]}`, LSB first out.
- Priority on `sr` when strobes coincide: uir > cdr > sdr. `vs_udr` samples the pre-edge `sr` and never modifies it.
- Command FSM, two states:
  - IDLE (`act_valid = 0`), PEND (`act_valid = 1`).
  - IDLE + `vs_udr` with valid channel → PEND. Load `jdo <= sr`, `act_ch <= ir_lat`, `act_mode <= sr[SR_W-1:SR_W-2]`.
  - PEND + `act_ready` without `vs_udr` → IDLE.
  - PEND + `vs_udr` + `act_ready` in the same cycle → stay in PEND and load the new command. No overrun.
  - PEND + `vs_udr` without `act_ready` → stay in PEND. The update is dropped, `jdo`/`act_*` are unchanged, and `overrun <= 1`.
- Update with `ir_lat >= NCH`: ignored. No state change, no overrun.
- `jdo`, `act_ch` and `act_mode` are stable while `act_valid` = 1.
- No-action commands (mode 2'b00) still use the handshake, so targets observe them.

## Timing
- Reset values: `sr = 0`, `tdo = 0`, `jdo = 0`, `act_valid = 0`, `act_ch = 0`, `act_mode = 0`, `overrun = 0`, `ir_lat = 0`.
- Reset mid-shift or mid-PEND discards everything immediately (asynchronous).
- `tdo` follows `sr[0]` with 0 combinational delay from the register. A new bit is visible the cycle after a `vs_cdr` or `vs_sdr` edge.
- `act_valid` rises 1 cycle after the `vs_udr` cycle. It falls 1 cycle after the accept cycle (`act_valid & act_ready`).
- Throughput: back-to-back updates are accepted every cycle if `act_ready` is held high.
- `overrun` rises 1 cycle after the dropped update. It is cleared at the next `vs_cdr` edge, unless an overrun occurs in that same cycle.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then capture:
  - Stimulus: `DATA_W = 32`, `NCH = 4`. `vs_uir` with `ir_in = 2`, `cap_data` ch2 = 0xDEADBEEF, `vs_cdr`, then 34× `vs_sdr` with `tdi = 0`.
  - Response: `tdo` sequence is 0xDEADBEEF LSB-first, then 0, 0.
- Update/accept:
  - Stimulus: shift in 34 bits with value `{2'b10, 0x12345678}`, `vs_udr`, `act_ready = 0` for 3 cycles, then 1.
  - Response: `act_valid` = 1 for 4 cycles, `act_ch = 2`, `act_mode = 2'b10`, `jdo = 0x2_1234_5678`; `act_valid` = 0 one cycle after accept.
- Overrun:
  - Stimulus: hold `act_ready = 0`; perform a second update with 0x0_0000_0001.
  - Response: `jdo` keeps 0x2_1234_5678 and `overrun` = 1. A following capture shifts out bit 33 = 1 and bit 32 = 1; afterwards `overrun` = 0.
- Simultaneous update and accept:
  - Stimulus: `vs_udr` and `act_ready` asserted in the same cycle while in PEND.
  - Response: new `jdo` is loaded, `act_valid` stays 1, `overrun` stays 0.
- Unimplemented channel:
  - Stimulus: `NCH = 3`, `ir_in = 3`; capture, then update.
  - Response: shifted-out data field is all zeros; `act_valid` stays 0; `overrun` stays 0.
- Asynchronous reset mid-shift while in PEND:
  - Stimulus: assert `reset_n = 0` during a shift with a command pending.
  - Response: all outputs go to 0 before the next clock edge.
